// File: rtl/bram_block_loader.sv
// Streams bytes into consecutive BRAM port-A locations from a programmed base for a programmed count.
// Optional running byte checksum output is enabled with LOADER_CHECKSUM_EN.
module bram_block_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 251
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              abort,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_LEFT  = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W:0]   start_len;
    logic [ADDR_W-1:0] ptr_next;
    logic              hs;

    // abort masks ready so a byte offered in the abort cycle is never consumed
    assign s_ready = (state == S_LOAD) && !abort;
    assign hs      = s_valid && s_ready;

    always_comb begin
        start_ptr = base_addr;
        if ({1'b0, base_addr} >= DEPTH_LEN) begin
            start_ptr = '0;
        end
        start_len = length;
        if (length > DEPTH_LEN) begin
            start_len = DEPTH_LEN;
        end
        ptr_next = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            ena <= 1'b0;
            wea <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ptr       <= start_ptr;
                        remaining <= start_len;
                        count     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (start_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_LOAD;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (hs) begin
                        ena       <= 1'b1;
                        wea       <= 1'b1;
                        addra     <= ptr;
                        dina      <= s_data;
                        ptr       <= ptr_next;
                        remaining <= remaining - 1'b1;
                        count     <= count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum  <= checksum + s_data;
`endif
                        // final byte: done rises together with its write strobe
                        if (remaining == ONE_LEFT) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_block_loader.sv
// Self-checking bench for bram_block_loader: vector table, directed corner cases and randomized loads
// checked cycle by cycle against an address-arithmetic reference model and a captured BRAM image.
module tb_bram_block_loader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 251;

    logic       clk = 1'b0;
    logic       reset, start, s_valid, s_ready, abort, ena, wea, busy, done;
    logic [7:0] base_addr, s_data, addra, dina;
    logic [8:0] length, count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    always #5 clk = ~clk;

    bram_block_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK100MHZ(clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .abort    (abort),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .busy     (busy),
        .done     (done),
        .count    (count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    int checks = 0;
    int failures = 0;

    // BRAM as seen through port A, and the image the model expects
    logic [7:0] dut_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] wr_addrs [$];

    always @(posedge clk) begin
        if (ena && wea) dut_mem[addra] <= dina;
    end

    // reference model: a load is (base, total); byte i lands at (base + i) mod DEPTH
    bit          m_loading = 1'b0;
    bit          m_done = 1'b0;
    int unsigned m_base = 0, m_total = 0, m_count = 0;
    logic [7:0]  m_sum = '0, m_addra = '0, m_dina = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_done    = 1'b0;
        m_count   = 0;
        m_sum     = '0;
        m_addra   = '0;
        m_dina    = '0;
    endtask

    // one clock: drive inputs, check ready, advance model, check registered outputs after the edge
    task automatic cycle(input logic st, input logic [7:0] b, input logic [8:0] l,
                         input logic v, input logic [7:0] d, input logic ab);
        logic hs;
        int unsigned a;
        start = st; base_addr = b; length = l; s_valid = v; s_data = d; abort = ab;
        #1;
        check("s_ready", 32'(s_ready), 32'(m_loading && !ab));
        hs = v && m_loading && !ab;
        if (!m_loading) begin
            if (st) begin
                m_base    = (int'(b) < DEPTH) ? int'(b) : 0;
                m_total   = (int'(l) > DEPTH) ? DEPTH : int'(l);
                m_count   = 0;
                m_sum     = '0;
                m_loading = (m_total != 0);
                m_done    = (m_total == 0);
            end
        end else if (ab) begin
            m_loading = 1'b0;
        end else if (hs) begin
            a = (m_base + m_count) % DEPTH;
            m_addra = 8'(a);
            m_dina  = d;
            ref_mem[a] = d;
            m_sum   = m_sum + d;
            m_count++;
            if (m_count == m_total) begin
                m_loading = 1'b0;
                m_done    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (wea) wr_addrs.push_back(addra);
        check("wea", 32'(wea), 32'(hs));
        check("ena", 32'(ena), 32'(hs));
        check("addra", 32'(addra), 32'(m_addra));
        check("dina", 32'(dina), 32'(m_dina));
        check("busy", 32'(busy), 32'(m_loading));
        check("done", 32'(done), 32'(m_done));
        check("count", 32'(count), 32'(m_count));
`ifdef LOADER_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(m_sum));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 9'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"}, 32'(ena), 32'd0);
        check({tag, "_wea"}, 32'(wea), 32'd0);
        check({tag, "_addra"}, 32'(addra), 32'd0);
        check({tag, "_dina"}, 32'(dina), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    // asserted mid-cycle so the outputs must clear without a clock edge
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        reset = 1'b1;
    endtask

    typedef struct {
        logic       st;
        logic [7:0] b;
        logic [8:0] l;
        logic       v;
        logic [7:0] d;
        logic       ab;
        logic       e_wea;
        logic [7:0] e_addra;
        logic [7:0] e_dina;
        logic       e_busy;
        logic       e_done;
        logic [8:0] e_count;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [8];
        logic [7:0]  exp_bytes [4];
        logic [7:0]  b;
        logic [8:0]  l;
        int unsigned guard, bad;

        vecs[0] = '{1'b1, 8'd0, 9'd4, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 9'd0};
        vecs[1] = '{1'b0, 8'd0, 9'd0, 1'b1, 8'h11, 1'b0, 1'b1, 8'd0, 8'h11, 1'b1, 1'b0, 9'd1};
        vecs[2] = '{1'b0, 8'd0, 9'd0, 1'b1, 8'h22, 1'b0, 1'b1, 8'd1, 8'h22, 1'b1, 1'b0, 9'd2};
        vecs[3] = '{1'b0, 8'd0, 9'd0, 1'b1, 8'h33, 1'b0, 1'b1, 8'd2, 8'h33, 1'b1, 1'b0, 9'd3};
        vecs[4] = '{1'b0, 8'd0, 9'd0, 1'b1, 8'h44, 1'b0, 1'b1, 8'd3, 8'h44, 1'b0, 1'b1, 9'd4};
        vecs[5] = '{1'b0, 8'd0, 9'd0, 1'b1, 8'h55, 1'b0, 1'b0, 8'd3, 8'h44, 1'b0, 1'b1, 9'd4};
        vecs[6] = '{1'b1, 8'd5, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 8'h44, 1'b0, 1'b1, 9'd0};
        vecs[7] = '{1'b0, 8'd0, 9'd0, 1'b1, 8'h66, 1'b0, 1'b0, 8'd3, 8'h44, 1'b0, 1'b1, 9'd0};
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;

        for (int a = 0; a < 256; a++) begin
            dut_mem[a] = '0;
            ref_mem[a] = '0;
        end

        reset = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        s_valid = 1'b0; s_data = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // basic 4-byte load, then a zero-length start
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].st, vecs[i].b, vecs[i].l, vecs[i].v, vecs[i].d, vecs[i].ab);
            check("vec_wea", 32'(wea), 32'(vecs[i].e_wea));
            check("vec_addra", 32'(addra), 32'(vecs[i].e_addra));
            check("vec_dina", 32'(dina), 32'(vecs[i].e_dina));
            check("vec_busy", 32'(busy), 32'(vecs[i].e_busy));
            check("vec_done", 32'(done), 32'(vecs[i].e_done));
            check("vec_count", 32'(count), 32'(vecs[i].e_count));
`ifdef LOADER_CHECKSUM_EN
            if (i == 4) check("vec_checksum", 32'(checksum), 32'h0000_00AA);
`endif
        end
        for (int i = 0; i < 4; i++) check("readback", 32'(dut_mem[i]), 32'(exp_bytes[i]));

        // wrap past the last valid address
        wr_addrs.delete();
        cycle(1'b1, 8'd249, 9'd4, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'(8'hA0 + i), 1'b0);
        check("wrap_nwrites", 32'(wr_addrs.size()), 32'd4);
        if (wr_addrs.size() == 4) begin
            check("wrap_a0", 32'(wr_addrs[0]), 32'd249);
            check("wrap_a1", 32'(wr_addrs[1]), 32'd250);
            check("wrap_a2", 32'(wr_addrs[2]), 32'd0);
            check("wrap_a3", 32'(wr_addrs[3]), 32'd1);
        end
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_count", 32'(count), 32'd4);

        // valid toggling every other cycle
        wr_addrs.delete();
        cycle(1'b1, 8'd100, 9'd6, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'd0, 9'd0, 1'((i % 2) == 0), 8'($urandom), 1'b0);
        check("toggle_nwrites", 32'(wr_addrs.size()), 32'd6);
        for (int i = 0; i < wr_addrs.size(); i++) check("toggle_addr", 32'(wr_addrs[i]), 32'(100 + i));
        check("toggle_done", 32'(done), 32'd1);

        // abort with a byte on offer, then a normal follow-up load
        wr_addrs.delete();
        cycle(1'b1, 8'd20, 9'd10, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'(8'h70 + i), 1'b0);
        cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'h7F, 1'b1);
        cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'h7E, 1'b0);
        check("abort_nwrites", 32'(wr_addrs.size()), 32'd3);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd3);
        cycle(1'b1, 8'd30, 9'd2, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'(8'hC0 + i), 1'b0);
        check("reload_done", 32'(done), 32'd1);
        check("reload_count", 32'(count), 32'd2);

        // reset in the middle of a load
        cycle(1'b1, 8'd10, 9'd5, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'(8'hD0 + i), 1'b0);
        do_reset();
        cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'hEE, 1'b0);
        idle(1);

        // randomized loads with stalls, stray starts, aborts and out-of-range bases
        for (int n = 0; n < 40; n++) begin
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) l = 9'd0;
            else l = 9'($urandom_range(1, (n % 5 == 0) ? DEPTH : 20));
            cycle(1'b1, b, l, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0));
            guard = 0;
            while (m_loading && guard < 2000) begin
                cycle(1'($urandom_range(0, 19) == 0), 8'($urandom), 9'($urandom_range(0, DEPTH)),
                      1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 149) == 0));
                guard++;
            end
            cycle(1'b0, 8'd0, 9'd0, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(2);

        bad = 0;
        for (int a = 0; a < int'(DEPTH); a++) if (dut_mem[a] !== ref_mem[a]) bad++;
        check("mem_readback_mismatches", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
